// File: rtl/window_generator.sv
// 3x3 window generator: raster pixel stream in, two line buffers, 3x3 neighbourhood out.
// Latency: one cycle from pixel accept to start_calculations for that window.
// Backpressure: pixel_ready drops while a window is pending and calc_ready is low.
// Optional WINDOW_COUNT_EN adds a saturating per-frame window_count output.
module window_generator #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  output logic       pixel_ready,
  output logic [7:0] windowBuffer [0:8],
  output logic       start_calculations,
  input  logic       calc_ready,
  output logic       frame_done
`ifdef WINDOW_COUNT_EN
  ,
  output logic [19:0] window_count
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [2:0] {IDLE, FILL, STREAM, HOLD, DONE} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_win;

  logic [7:0] line_buf0 [0:IMG_WIDTH-1];
  logic [7:0] line_buf1 [0:IMG_WIDTH-1];

  logic          accept;
  logic          consume;
  logic          emit;
  logic          end_of_line;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;

  // The final window of a frame blocks further pixels until the next frame_start.
  assign pixel_ready = (state == FILL) || (state == STREAM) ||
                       ((state == HOLD) && calc_ready && !last_win);
  assign accept      = pixel_valid && pixel_ready;
  assign consume     = start_calculations && calc_ready;
  // Columns 0 and 1 only refill the window, so no window ever spans a line wrap.
  assign emit        = (row >= ROW_TWO) && (col >= COL_TWO);
  assign end_of_line = (col == COL_LAST);
  assign col_nxt     = end_of_line ? '0 : col + 1'b1;
  assign row_nxt     = end_of_line ? row + 1'b1 : row;

  // Frame control FSM: raster position, window handshake and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      col                <= '0;
      row                <= '0;
      last_win           <= 1'b0;
      start_calculations <= 1'b0;
      frame_done         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state    <= FILL;
            col      <= '0;
            row      <= '0;
            last_win <= 1'b0;
          end
        end
        FILL, STREAM, HOLD: begin
          if (accept) begin
            col <= col_nxt;
            row <= row_nxt;
            if (emit) begin
              state              <= HOLD;
              start_calculations <= 1'b1;
              last_win           <= end_of_line && (row == ROW_LAST);
            end else begin
              state              <= ((row_nxt >= ROW_TWO) && (col_nxt >= COL_TWO)) ? STREAM : FILL;
              start_calculations <= 1'b0;
            end
          end else if (consume) begin
            start_calculations <= 1'b0;
            if (last_win) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state <= ((row >= ROW_TWO) && (col >= COL_TWO)) ? STREAM : FILL;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Shift the window left one column per accepted pixel; new right column comes from the line buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) windowBuffer[i] <= '0;
    end else if (accept) begin
      windowBuffer[0] <= windowBuffer[1];
      windowBuffer[1] <= windowBuffer[2];
      windowBuffer[2] <= line_buf1[col];
      windowBuffer[3] <= windowBuffer[4];
      windowBuffer[4] <= windowBuffer[5];
      windowBuffer[5] <= line_buf0[col];
      windowBuffer[6] <= windowBuffer[7];
      windowBuffer[7] <= windowBuffer[8];
      windowBuffer[8] <= pixel_in;
    end
  end

  // Line buffers age by one row per accepted pixel; contents are don't-care until refilled.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf1[col] <= line_buf0[col];
      line_buf0[col] <= pixel_in;
    end
  end

`ifdef WINDOW_COUNT_EN
  // Count consumed windows in the current frame, saturating at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      window_count <= '0;
    end else if ((state == IDLE) && frame_start) begin
      window_count <= '0;
    end else if (consume && (window_count != 20'hFFFFF)) begin
      window_count <= window_count + 20'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_generator.sv
// Directed bench for window_generator with a 4x4 image, pixel(r,c) = 10*r + c.
module tb_window_generator;

  typedef logic [0:8][7:0] win_t;
  typedef struct packed {
    win_t w;
    int   r;
    int   c;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic [7:0] pixel_in = 8'd0;
  logic       pixel_valid = 1'b0;
  logic       pixel_ready;
  logic [7:0] win [0:8];
  logic       start_calculations;
  logic       calc_ready = 1'b1;
  logic       frame_done;
`ifdef WINDOW_COUNT_EN
  logic [19:0] window_count;
`endif

  int total = 0;
  int passed = 0;
  vec_t tbl [4];

  window_generator #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .pixel_in(pixel_in),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .windowBuffer(win),
    .start_calculations(start_calculations),
    .calc_ready(calc_ready),
    .frame_done(frame_done)
`ifdef WINDOW_COUNT_EN
    ,
    .window_count(window_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_win(input string name, input win_t act, input win_t exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic win_t cur_win();
    win_t w;
    for (int i = 0; i < 9; i++) w[i] = win[i];
    return w;
  endfunction

  function automatic int gy(input win_t w);
    return (int'(w[6]) + 2 * int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2 * int'(w[1]) + int'(w[2]));
  endfunction

  function automatic logic [7:0] pix(input bit uniform, input int p);
    if (uniform) return 8'd255;
    return 8'(10 * (p / 4) + (p % 4));
  endfunction

  // One full 4x4 frame; optionally stall the first window for stall_cycles cycles.
  task automatic run_frame(input bit uniform, input int stall_cycles);
    int   p;
    int   nwin;
    int   stalled;
    bit   seen_done;
    bit   xfer;
    bit   exp_start;
    win_t exp_w;
    p = 0; nwin = 0; stalled = 0; seen_done = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
`ifdef WINDOW_COUNT_EN
    chk("count_cleared", window_count, 0);
`endif
    pixel_valid = 1'b1;
    pixel_in = pix(uniform, 0);
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      calc_ready = !(start_calculations && nwin == 0 && stalled < stall_cycles);
      #1;
      xfer = pixel_valid && pixel_ready;
      if (!calc_ready) begin
        chk("stall_start", start_calculations, 1);
        chk_win("stall_win", cur_win(), tbl[0].w);
        chk("stall_ready", pixel_ready, 0);
        stalled++;
      end
      if (start_calculations && calc_ready) begin
        exp_w = uniform ? {9{8'd255}} : tbl[nwin % 4].w;
        chk_win(uniform ? "uniform_win" : "table_win", cur_win(), exp_w);
        chk("gy", gy(cur_win()), uniform ? 0 : 80);
        nwin++;
      end
      exp_start = xfer && ((p / 4) >= 2) && ((p % 4) >= 2);
      step();
      if (stall_cycles == 0) chk("start_seq", start_calculations, exp_start);
      if (xfer && p == 10 && !uniform) begin
        chk("first_start", start_calculations, 1);
        chk_win("first_win", cur_win(), tbl[0].w);
      end
      if (xfer) begin
        p++;
        pixel_valid = (p < 16);
        pixel_in = pix(uniform, p);
      end
      if (frame_done) seen_done = 1'b1;
    end
    chk("frame_done_seen", seen_done, 1);
    chk("window_total", nwin, 4);
    chk("pixels_accepted", p, 16);
    calc_ready = 1'b1;
    pixel_valid = 1'b1;
    pixel_in = 8'd99;
    step();
    chk("done_single_pulse", frame_done, 0);
    chk("ready_after_done", pixel_ready, 0);
`ifdef WINDOW_COUNT_EN
    chk("count_at_done", window_count, 4);
`endif
    pixel_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{w: {8'd0,  8'd1,  8'd2,  8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22}, r: 1, c: 1};
    tbl[1] = '{w: {8'd1,  8'd2,  8'd3,  8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23}, r: 1, c: 2};
    tbl[2] = '{w: {8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22, 8'd30, 8'd31, 8'd32}, r: 2, c: 1};
    tbl[3] = '{w: {8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23, 8'd31, 8'd32, 8'd33}, r: 2, c: 2};

    step();
    step();
    chk("rst_ready", pixel_ready, 0);
    chk("rst_start", start_calculations, 0);
    chk("rst_done", frame_done, 0);
    chk_win("rst_win", cur_win(), '0);
    rst = 1'b0;
    pixel_valid = 1'b1;
    step();
    chk("idle_ready", pixel_ready, 0);
    pixel_valid = 1'b0;

    run_frame(1'b0, 0);
    run_frame(1'b0, 5);
    run_frame(1'b1, 0);

    // Reset partway through a frame, then confirm a clean restart.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pixel_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pixel_in = pix(1'b0, i);
      step();
    end
    pixel_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ready", pixel_ready, 0);
    chk("midrst_start", start_calculations, 0);
    chk("midrst_done", frame_done, 0);
    chk_win("midrst_win", cur_win(), '0);
    pixel_valid = 1'b1;
    step();
    chk("midrst_idle_ready", pixel_ready, 0);
    pixel_valid = 1'b0;
    run_frame(1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
